adc_lane_serializer: RTL and testbench

- Parametrised single-clock successor to the ADC rate changer.
- Accepts one parallel ADC word per input beat: LANES time-ordered I/Q sample pairs, each WIDTH bits.
- Emits one I/Q pair per output beat, lane 0 first, over a valid/ready stream.
- Sits between the ADC capture logic and the DSP chain. It adds buffering, backpressure, a sticky overflow flag and a sample counter, none of which the fixed 2:1 changer has.

---
 rtl/adc_pkg.sv | 15 +
 rtl/adc_word_fifo.sv | 63 ++++++
 rtl/adc_lane_serializer.sv | 116 +++++++++++
 tb/tb_adc_lane_serializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC lane serializer.
//   DEFAULT_WIDTH : default bits per I or Q sample
//   sample_t      : one sample at the default width
//   lane_idx_w()  : width of a lane index for a given lane count (never below 1)
package adc_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef logic [DEFAULT_WIDTH-1:0] sample_t;

  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/adc_word_fifo.sv
// Generic synchronous circular FIFO with full/empty flags and the head word
// presented from registered storage (no flow-through from wr_data).
// Ports:
//   clkin   : clock, rising edge
//   resetn  : synchronous active-low reset, empties the FIFO
//   wr_en   : push wr_data (ignored while full)
//   wr_data : word to push
//   rd_en   : pop the head word (ignored while empty)
//   full    : DEPTH words held
//   empty   : no words held
//   head    : oldest word; only meaningful while !empty
module adc_word_fifo #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clkin,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PtrOne = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_rd) rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clkin) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is only observed through head while non-empty.
  always_ff @(posedge clkin) begin
    if (resetn && do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/adc_lane_serializer.sv
// Buffers parallel ADC words (LANES time-ordered I/Q pairs) and emits one I/Q
// pair per output beat, lane 0 first, over a valid/ready stream.
// Ports:
//   clkin, resetn          : clock and synchronous active-low reset
//   i_in, q_in, in_valid   : input word, lane k at [k*WIDTH +: WIDTH]
//   in_ready               : buffer has room (depends on state only)
//   i_out, q_out, out_lane : current pair and its lane index
//   out_last, out_valid    : last lane of a word / pair present
//   out_ready              : downstream accepts the pair
//   overflow, clear_ovf    : sticky drop flag and its clear (set wins)
//   sample_cnt             : accepted output pairs, wrapping
module adc_lane_serializer
  import adc_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic                          clkin,
  input  logic                          resetn,
  input  logic [LANES*WIDTH-1:0]        i_in,
  input  logic [LANES*WIDTH-1:0]        q_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              i_out,
  output logic [WIDTH-1:0]              q_out,
  output logic [lane_idx_w(LANES)-1:0]  out_lane,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  input  logic                          clear_ovf,
  output logic [CNT_W-1:0]              sample_cnt
);

  localparam int unsigned LW  = lane_idx_w(LANES);
  localparam int unsigned HW  = LANES * WIDTH;
  localparam logic [LW-1:0] LastLane = LW'(LANES - 1);

  logic [2*HW-1:0]  head;
  logic [HW-1:0]    head_i, head_q;
  logic             full, empty;
  logic [LW-1:0]    lane_q, lane_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_lane, xfer, pop;
  logic [WIDTH-1:0] i_sel, q_sel;

  // Q occupies the upper half of each stored word.
  adc_word_fifo #(
    .DW    (2 * HW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clkin   (clkin),
    .resetn  (resetn),
    .wr_en   (in_valid),
    .wr_data ({q_in, i_in}),
    .rd_en   (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  assign head_i    = head[HW-1:0];
  assign head_q    = head[2*HW-1:HW];
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign last_lane = (lane_q == LastLane);
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && last_lane;

  always_comb begin
    i_sel = '0;
    q_sel = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_q == LW'(k)) begin
        i_sel = head_i[k*WIDTH +: WIDTH];
        q_sel = head_q[k*WIDTH +: WIDTH];
      end
    end
  end

  // Gate with out_valid so an empty buffer shows zeros, not stale storage.
  assign i_out      = out_valid ? i_sel : '0;
  assign q_out      = out_valid ? q_sel : '0;
  assign out_lane   = lane_q;
  assign out_last   = out_valid && last_lane;
  assign overflow   = ovf_q;
  assign sample_cnt = cnt_q;

  always_comb begin
    lane_d = lane_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (xfer) begin
      lane_d = last_lane ? '0 : lane_q + LW'(1);
      cnt_d  = cnt_q + CNT_W'(1);
    end
    if (in_valid && !in_ready) ovf_d = 1'b1;
    else if (clear_ovf)        ovf_d = 1'b0;
  end

  always_ff @(posedge clkin) begin
    if (!resetn) begin
      lane_q <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      lane_q <= lane_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_adc_lane_serializer.sv
module tb_adc_lane_serializer;

  localparam int LA = 4;
  localparam int DA = 2;
  localparam int WA = 16;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Instance A: LANES=4, DEPTH=2, CNT_W=32
  logic [LA*WA-1:0] a_i_in, a_q_in;
  logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic             a_overflow, a_clear_ovf;
  logic [WA-1:0]    a_i_out, a_q_out;
  logic [1:0]       a_out_lane;
  logic [31:0]      a_sample_cnt;

  // Instance B: LANES=2, DEPTH=2, CNT_W=4
  logic [31:0] b_i_in, b_q_in;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic        b_overflow, b_clear_ovf;
  logic [15:0] b_i_out, b_q_out;
  logic [0:0]  b_out_lane;
  logic [3:0]  b_sample_cnt;

  adc_lane_serializer #(.WIDTH(WA), .LANES(LA), .DEPTH(DA), .CNT_W(32)) dut_a (
    .clkin(clk), .resetn(resetn), .i_in(a_i_in), .q_in(a_q_in), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .i_out(a_i_out), .q_out(a_q_out), .out_lane(a_out_lane),
    .out_last(a_out_last), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .overflow(a_overflow), .clear_ovf(a_clear_ovf), .sample_cnt(a_sample_cnt)
  );

  adc_lane_serializer #(.WIDTH(16), .LANES(2), .DEPTH(2), .CNT_W(4)) dut_b (
    .clkin(clk), .resetn(resetn), .i_in(b_i_in), .q_in(b_q_in), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .i_out(b_i_out), .q_out(b_q_out), .out_lane(b_out_lane),
    .out_last(b_out_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .overflow(b_overflow), .clear_ovf(b_clear_ovf), .sample_cnt(b_sample_cnt)
  );

  int tests  = 0;
  int failed = 0;

  // Reference for A: pending output samples in time order, plus flag and count.
  logic [WA-1:0] mi[$];
  logic [WA-1:0] mq[$];
  logic          m_ovf;
  logic [31:0]   m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a();
    int n;
    int lane;
    bit v;
    n    = mi.size();
    v    = (n > 0);
    lane = v ? (LA - (n % LA)) % LA : 0;
    chk("a_in_ready", 64'(a_in_ready), 64'(((n + LA - 1) / LA) < DA));
    chk("a_out_valid", 64'(a_out_valid), 64'(v));
    chk("a_i_out", 64'(a_i_out), v ? 64'(mi[0]) : 64'd0);
    chk("a_q_out", 64'(a_q_out), v ? 64'(mq[0]) : 64'd0);
    chk("a_out_lane", 64'(a_out_lane), 64'(lane));
    chk("a_out_last", 64'(a_out_last), 64'(v && lane == LA - 1));
    chk("a_overflow", 64'(a_overflow), 64'(m_ovf));
    chk("a_sample_cnt", 64'(a_sample_cnt), 64'(m_cnt));
  endtask

  // One clock: predict from current inputs, advance, check at the falling edge.
  task automatic step();
    bit rdy, push, drop, xfer, rst;
    logic [WA-1:0] dummy;
    rdy  = ((mi.size() + LA - 1) / LA) < DA;
    push = a_in_valid && rdy;
    drop = a_in_valid && !rdy;
    xfer = (mi.size() > 0) && a_out_ready;
    rst  = !resetn;
    @(posedge clk);
    if (rst) begin
      mi.delete();
      mq.delete();
      m_ovf = 1'b0;
      m_cnt = '0;
    end else begin
      if (xfer) begin
        dummy = mi.pop_front();
        dummy = mq.pop_front();
        m_cnt = m_cnt + 32'd1;
      end
      if (push) begin
        for (int k = 0; k < LA; k++) begin
          mi.push_back(a_i_in[k*WA +: WA]);
          mq.push_back(a_q_in[k*WA +: WA]);
        end
      end
      if (drop)             m_ovf = 1'b1;
      else if (a_clear_ovf) m_ovf = 1'b0;
    end
    @(negedge clk);
    check_a();
  endtask

  task automatic rand_word();
    a_i_in = {$urandom, $urandom};
    a_q_in = {$urandom, $urandom};
  endtask

  initial begin
    resetn = 1'b0;
    a_i_in = '0; a_q_in = '0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_clear_ovf = 1'b0;
    b_i_in = '0; b_q_in = '0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_clear_ovf = 1'b0;
    m_ovf = 1'b0; m_cnt = '0;
    @(negedge clk);

    // Reset held with in_valid high
    a_in_valid = 1'b1; b_in_valid = 1'b1;
    repeat (3) begin
      step();
      chk("b_rst_in_ready", 64'(b_in_ready), 64'd1);
      chk("b_rst_out_valid", 64'(b_out_valid), 64'd0);
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    resetn = 1'b1;
    step();

    // Basic ordering on B (LANES=2)
    b_i_in = {16'd1, 16'd0}; b_q_in = {16'd1, 16'd0};
    b_in_valid = 1'b1; b_out_ready = 1'b1;
    step();
    b_in_valid = 1'b0;
    chk("b_ord0_valid", 64'(b_out_valid), 64'd1);
    chk("b_ord0_i", 64'(b_i_out), 64'd0);
    chk("b_ord0_last", 64'(b_out_last), 64'd0);
    step();
    chk("b_ord1_i", 64'(b_i_out), 64'd1);
    chk("b_ord1_q", 64'(b_q_out), 64'd1);
    chk("b_ord1_lane", 64'(b_out_lane), 64'd1);
    chk("b_ord1_last", 64'(b_out_last), 64'd1);
    step();
    chk("b_ord_done_valid", 64'(b_out_valid), 64'd0);
    chk("b_ord_cnt", 64'(b_sample_cnt), 64'd2);

    // Counter wrap on B: 17 transfers with CNT_W=4
    resetn = 1'b0; step(); resetn = 1'b1;
    for (int e = 0; e < 18; e++) begin
      b_in_valid  = (e % 2 == 0) && (e <= 16);
      b_i_in      = {16'(e + 100), 16'(e)};
      b_out_ready = 1'b1;
      step();
    end
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    chk("b_wrap_cnt", 64'(b_sample_cnt), 64'd1);
    chk("b_wrap_valid", 64'(b_out_valid), 64'd1);
    chk("b_wrap_lane", 64'(b_out_lane), 64'd1);
    chk("b_wrap_i", 64'(b_i_out), 64'd116);
    chk("b_wrap_ovf", 64'(b_overflow), 64'd0);

    // Streaming on A: one word every LANES cycles, lane k = 4n+k
    resetn = 1'b0; step(); resetn = 1'b1;
    a_out_ready = 1'b1;
    for (int c = 0; c < 64 * LA + LA; c++) begin
      a_in_valid = (c % LA == 0) && (c < 64 * LA);
      for (int k = 0; k < LA; k++) a_i_in[k*WA +: WA] = 16'((c / LA) * LA + k);
      a_q_in = {$urandom, $urandom};
      step();
    end
    a_in_valid = 1'b0;
    chk("a_stream_cnt", 64'(a_sample_cnt), 64'd256);
    chk("a_stream_ovf", 64'(a_overflow), 64'd0);

    // Backpressure: three pushes into a 2-deep buffer
    a_out_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      rand_word();
      a_in_valid = 1'b1;
      step();
    end
    chk("a_bp_in_ready", 64'(a_in_ready), 64'd0);
    chk("a_bp_ovf", 64'(a_overflow), 64'd1);

    // Clear coinciding with a drop, then clear alone
    a_clear_ovf = 1'b1;
    step();
    chk("a_clr_set_wins", 64'(a_overflow), 64'd1);
    a_in_valid = 1'b0;
    step();
    chk("a_clr_alone", 64'(a_overflow), 64'd0);
    a_clear_ovf = 1'b0;
    a_out_ready = 1'b1;
    repeat (2 * LA + 1) step();
    chk("a_bp_drained", 64'(a_out_valid), 64'd0);

    // Mid-word reset during lane 1
    rand_word();
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    step();
    chk("a_mid_lane1", 64'(a_out_lane), 64'd1);
    resetn = 1'b0; step(); resetn = 1'b1;
    repeat (3) step();
    chk("a_mid_idle", 64'(a_out_valid), 64'd0);
    rand_word();
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    chk("a_mid_new_lane0", 64'(a_out_lane), 64'd0);
    chk("a_mid_new_valid", 64'(a_out_valid), 64'd1);

    // Randomized traffic against the model
    for (int r = 0; r < 400; r++) begin
      rand_word();
      a_in_valid  = ($urandom_range(0, 1) == 1);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_clear_ovf = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
